lsu_ctrl: RTL and testbench

Load/store unit controller between the MEM pipeline stage and the data-memory bus.
- Accepts one load/store at a time and validates alignment and funct3.
- Generates the byte strobe and lane-shifted store data, and issues a req/gnt/rvalid bus transaction.
- Extracts and sign- or zero-extends load data.
- Returns a single-cycle response with an exception code, and stalls the pipeline while busy.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_load_extend.sv | 23 ++
 rtl/lsu_ctrl.sv | 116 +++++++++++
 tb/tb_lsu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3/exception encodings, controller states and byte-lane strobe helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISAL = 2'b01;
    localparam logic [1:0] EXC_ILL   = 2'b10;
    localparam logic [1:0] EXC_TMO   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} lsu_state_e;

    function automatic logic [3:0] lane_strobe(input logic [2:0] funct3, input logic [1:0] a);
        return (funct3 == F3_B || funct3 == F3_BU) ? 4'b0001 << a :
               (funct3 == F3_H || funct3 == F3_HU) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b   = rdata[{addr_lo, 3'b000} +: 8];
        h   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext = funct3 == F3_B  ? {{24{b[7]}}, b} :
              funct3 == F3_BU ? {24'b0, b} :
              funct3 == F3_H  ? {{16{h[15]}}, h} :
              funct3 == F3_HU ? {16'b0, h} : rdata;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller driving a req/gnt/rvalid data bus.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strobe,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e st, nxt;
    logic            is_store_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q, wdata_q, rdata_q, ext, wmask;
    logic [3:0]      strobe_q;
    logic [1:0]      exc_q;
    logic [TO_W-1:0] cnt_q;
    logic            acc, ill, mis, tmo, cap, tmo_fire;

    assign acc = st == S_IDLE && req_valid && !flush;
    assign ill = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 || (is_store && funct3[2]);
    assign mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign tmo = cnt_q >= TO_W'(TIMEOUT_CYC - 1);
    assign cap = mem_rvalid && ((st == S_ISSUE && mem_gnt && !is_store_q) || st == S_WAIT);
    assign tmo_fire = nxt == S_RESP && ((st == S_ISSUE && !mem_gnt) || (st == S_WAIT && !mem_rvalid));
    assign wmask = funct3[1:0] == 2'b00 ? 32'h0000_00ff : funct3[1:0] == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;

    lsu_load_extend u_ext (
        .rdata   (mem_rdata),
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .ext     (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= S_IDLE;
        else
            st <= nxt;
    end

    // A grant or data beat wins over a timeout landing in the same cycle.
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:  if (acc) nxt = (ill || mis) ? S_RESP : S_ISSUE;
            S_ISSUE: nxt = flush ? ((mem_gnt && !is_store_q && !mem_rvalid) ? S_DRAIN : S_IDLE) :
                           mem_gnt ? ((is_store_q || mem_rvalid) ? S_RESP : S_WAIT) :
                           tmo ? S_RESP : S_ISSUE;
            S_WAIT:  nxt = mem_rvalid ? (flush ? S_IDLE : S_RESP) :
                           flush ? S_DRAIN : tmo ? S_RESP : S_WAIT;
            S_DRAIN: nxt = (mem_rvalid || tmo) ? S_IDLE : S_DRAIN;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strobe_q   <= '0;
            exc_q      <= EXC_NONE;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else if (acc) begin
            is_store_q <= is_store;
            f3_q       <= funct3;
            addr_q     <= addr;
            wdata_q    <= (wdata & wmask) << {addr[1:0], 3'b000};
            strobe_q   <= lane_strobe(funct3, addr[1:0]);
            exc_q      <= ill ? EXC_ILL : mis ? EXC_MISAL : EXC_NONE;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            if (st inside {S_ISSUE, S_WAIT, S_DRAIN}) cnt_q <= cnt_q + 1'b1;
            if (cap) rdata_q <= ext;
            if (tmo_fire) exc_q <= EXC_TMO;
        end
    end

    always_comb begin
        req_ready  = st == S_IDLE;
        stall      = st != S_IDLE;
        mem_req    = st == S_ISSUE;
        mem_we     = is_store_q;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        mem_strobe = strobe_q;
        resp_valid = st == S_RESP;
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_exc   = resp_valid ? exc_q : EXC_NONE;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized load/store traffic against an arithmetic reference model with a response scoreboard.
module tb_lsu_ctrl;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, is_store = 0, flush = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        req_ready, resp_valid, stall, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [1:0]  resp_exc;
    logic [3:0]  mem_strobe;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;

    lsu_ctrl #(.TIMEOUT_CYC(64), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strobe(mem_strobe), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    typedef struct { logic [31:0] rd; logic [1:0] exc; int at; } exp_t;
    exp_t sb[$];
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            exp_t e;
            if (sb.size() == 0) chk("spurious_resp", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_exc", {30'b0, resp_exc}, {30'b0, e.exc});
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a, wd, rw,
                                  output logic [1:0] exc, output logic [31:0] rd,
                                  output logic [3:0] strb, output logic [31:0] mwd);
        int n, off;
        longint unsigned mask, v;
        n    = 1 << f3[1:0];
        off  = int'(a % 4);
        mask = (64'd1 << (8 * n)) - 1;
        exc  = (f3 == 3 || f3 >= 6 || (st && f3 >= 4)) ? 2'd2 : (a % n != 0) ? 2'd1 : 2'd0;
        strb = 4'(((1 << n) - 1) << off);
        mwd  = 32'((wd & mask) << (8 * off));
        v    = (rw >> (8 * off)) & mask;
        if (f3 < 4 && n < 4 && v[8 * n - 1]) v = v | ~mask;
        rd   = (st || exc != 0) ? 32'd0 : 32'(v);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", {31'b0, req_ready}, 1);
    endtask

    // Issues one access and plays the bus: grant after gd cycles, read data rd cycles after grant.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a, wd,
                          input int gd, input int rd, input logic [31:0] rw);
        logic [1:0]  exc;
        logic [31:0] erd, mwd;
        logic [3:0]  strb;
        exp_t        e;
        int          k;
        wait_idle();
        model(st, f3, a, wd, rw, exc, erd, strb, mwd);
        k = cyc;
        e.rd  = erd;
        e.exc = exc;
        e.at  = exc != 0 ? k + 1 : st ? k + gd + 2 : k + gd + (rd == 0 ? 2 : rd + 2);
        sb.push_back(e);
        req_valid = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 0;
        if (exc != 0) begin
            chk("no_bus", {31'b0, mem_req}, 0);
            return;
        end
        chk("mem_req", {31'b0, mem_req}, 1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", {31'b0, mem_we}, {31'b0, st});
        chk("mem_strobe", {28'b0, mem_strobe}, {28'b0, strb});
        if (st) chk("mem_wdata", mem_wdata, mwd);
        repeat (gd) begin
            @(negedge clk);
            chk("req_held", {31'b0, mem_req}, 1);
        end
        mem_gnt = 1;
        if (!st && rd == 0) begin mem_rvalid = 1; mem_rdata = rw; end
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
        chk("req_drop", {31'b0, mem_req}, 0);
        if (!st && rd > 0) begin
            repeat (rd - 1) @(negedge clk);
            mem_rvalid = 1; mem_rdata = rw;
            @(negedge clk);
            mem_rvalid = 0; mem_rdata = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_strobe", {28'b0, mem_strobe}, 0);
        rst_n = 1;
        @(negedge clk);

        access(1, 3'b010, 32'h1000, 32'hDEADBEEF, 0, 0, 0);
        access(1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0);
        access(0, 3'b000, 32'h1003, 0, 0, 1, 32'h80FF1234);
        access(0, 3'b100, 32'h1003, 0, 0, 1, 32'h80FF1234);
        access(0, 3'b001, 32'h2001, 0, 0, 0, 0);
        access(0, 3'b011, 32'h2000, 0, 0, 0, 0);
        access(1, 3'b100, 32'h2000, 32'h1234, 0, 0, 0);
        access(0, 3'b101, 32'h1002, 0, 2, 0, 32'h8001FFFF);

        // lw with no grant: request held for the full timeout window
        wait_idle();
        e.rd = 0; e.exc = 2'd3; e.at = cyc + 65;
        sb.push_back(e);
        req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h3000;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (mem_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_req_cycles", n, 64);

        // flush in ISSUE before grant: dropped, no response
        wait_idle();
        req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h3100;
        @(negedge clk);
        req_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_issue_req", {31'b0, mem_req}, 0);
        chk("flush_issue_ready", {31'b0, req_ready}, 1);

        // flush in WAIT: drain the late rvalid silently
        wait_idle();
        req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h3200;
        @(negedge clk);
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        repeat (4) begin
            chk("drain_stall", {31'b0, stall}, 1);
            @(negedge clk);
        end
        mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        mem_rvalid = 0;
        chk("drain_ready", {31'b0, req_ready}, 1);
        chk("drain_stall_off", {31'b0, stall}, 0);

        // reset in WAIT abandons the load immediately
        wait_idle();
        req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h3300;
        @(negedge clk);
        req_valid = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        rst_n = 0;
        #1;
        chk("arst_mem_req", {31'b0, mem_req}, 0);
        chk("arst_resp_valid", {31'b0, resp_valid}, 0);
        chk("arst_ready", {31'b0, req_ready}, 1);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 0;
        chk("post_rst_ready", {31'b0, req_ready}, 1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            access(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        repeat (6) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
